// File: rtl/k12a_skip_counter_pkg.sv
// Shared skip-select encodings for the k12a skip logic.
// Encodings 0-3 match the original 2-bit skip_sel_t; codes 5-7 are reserved.
package k12a_skip_counter_pkg;

  localparam int unsigned SKIP_SEL_W = 3;

  typedef enum logic [SKIP_SEL_W-1:0] {
    SKIP_SEL_HOLD               = 3'd0,
    SKIP_SEL_0                  = 3'd1,
    SKIP_SEL_CONDITION          = 3'd2,
    SKIP_SEL_CONDITION_INVERTED = 3'd3,
    SKIP_SEL_ALWAYS             = 3'd4
  } skip_sel_t;

  // True for the selects that may start a skip run; reserved codes never do.
  function automatic logic skip_sel_loads(input logic [SKIP_SEL_W-1:0] sel);
    logic loads;
    loads = 1'b0;
    case (sel)
      SKIP_SEL_CONDITION,
      SKIP_SEL_CONDITION_INVERTED,
      SKIP_SEL_ALWAYS: loads = 1'b1;
      default:         loads = 1'b0;
    endcase
    return loads;
  endfunction

endpackage

// File: rtl/k12a_skip_cond_mux.sv
// Condition select and skip load-value generation for k12a_skip_counter.
// Out-of-range cond_idx reads as a false condition.
module k12a_skip_cond_mux
  import k12a_skip_counter_pkg::*;
#(
  parameter int unsigned NUM_COND   = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned COND_IDX_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1
) (
  input  logic [NUM_COND-1:0]   cond_in,
  input  logic [COND_IDX_W-1:0] cond_idx,
  input  logic [SKIP_SEL_W-1:0] skip_sel,
  input  logic [CNT_W-1:0]      skip_len,
  output logic                  load_req,
  output logic [CNT_W-1:0]      load_val
);

  logic cond;

  // Explicit compare loop keeps out-of-range indices from reading past cond_in.
  always_comb begin
    cond = 1'b0;
    for (int unsigned i = 0; i < NUM_COND; i++) begin
      if (cond_idx == COND_IDX_W'(i)) begin
        cond = cond_in[i];
      end
    end
  end

  always_comb begin
    load_req = skip_sel_loads(skip_sel);
    load_val = '0;
    case (skip_sel)
      SKIP_SEL_CONDITION:          load_val = cond  ? skip_len : '0;
      SKIP_SEL_CONDITION_INVERTED: load_val = !cond ? skip_len : '0;
      SKIP_SEL_ALWAYS:             load_val = skip_len;
      default:                     load_val = '0;
    endcase
  end

endmodule

// File: rtl/k12a_skip_counter.sv
// Multi-instruction skip counter: loads a run length on a selected condition
// and suppresses that many following instructions as they retire.
module k12a_skip_counter
  import k12a_skip_counter_pkg::*;
#(
  parameter int unsigned NUM_COND   = 4,
  parameter int unsigned CNT_W      = 3,
  localparam int unsigned COND_IDX_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1
) (
  input  logic                  cpu_clock,
  input  logic                  reset_n,
  input  logic [NUM_COND-1:0]   cond_in,
  input  logic [COND_IDX_W-1:0] cond_idx,
  input  logic [SKIP_SEL_W-1:0] skip_sel,
  input  logic [CNT_W-1:0]      skip_len,
  input  logic                  instr_retire,
  output logic                  skip,
  output logic [CNT_W-1:0]      skip_count,
  output logic                  skip_done
);

  logic             load_req;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  k12a_skip_cond_mux #(
    .NUM_COND  (NUM_COND),
    .CNT_W     (CNT_W),
    .COND_IDX_W(COND_IDX_W)
  ) u_cond_mux (
    .cond_in (cond_in),
    .cond_idx(cond_idx),
    .skip_sel(skip_sel),
    .skip_len(skip_len),
    .load_req(load_req),
    .load_val(load_val)
  );

  // CLEAR beats everything; loads only start from idle, so a retire in the
  // loading cycle belongs to the loading instruction and is not counted.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (skip_sel == SKIP_SEL_0) begin
      count_d = '0;
    end else if (count_q == '0) begin
      if (load_req) begin
        count_d = load_val;
      end
    end else if (instr_retire) begin
      count_d = count_q - CNT_W'(1);
      done_d  = (count_q == CNT_W'(1));
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign skip       = (count_q != '0);
  assign skip_count = count_q;
  assign skip_done  = done_q;

endmodule

// File: tb/tb_k12a_skip_counter.sv
// Self-checking bench for k12a_skip_counter: directed scenarios plus random
// traffic checked against a behavioural model of the skip run.
module tb_k12a_skip_counter;

  localparam int NC = 3;
  localparam int CW = 3;
  localparam int IW = 2;

  logic          cpu_clock;
  logic          reset_n;
  logic [NC-1:0] cond_in;
  logic [IW-1:0] cond_idx;
  logic [2:0]    skip_sel;
  logic [CW-1:0] skip_len;
  logic          instr_retire;
  logic          skip;
  logic [CW-1:0] skip_count;
  logic          skip_done;

  int errors;
  int checks;

  // Reference: remaining instructions to skip, and whether the run just ended.
  int m_remaining;
  bit m_done;

  k12a_skip_counter #(
    .NUM_COND(NC),
    .CNT_W   (CW)
  ) dut (
    .cpu_clock   (cpu_clock),
    .reset_n     (reset_n),
    .cond_in     (cond_in),
    .cond_idx    (cond_idx),
    .skip_sel    (skip_sel),
    .skip_len    (skip_len),
    .instr_retire(instr_retire),
    .skip        (skip),
    .skip_count  (skip_count),
    .skip_done   (skip_done)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".skip"},  32'(skip),       32'(m_remaining != 0));
    check({tag, ".count"}, 32'(skip_count), 32'(m_remaining));
    check({tag, ".done"},  32'(skip_done),  32'(m_done));
  endtask

  // Model of one instruction-boundary edge, written from the skip rules.
  task automatic model_edge(input int sel, input int idx, input int cin,
                            input int len, input bit ret);
    bit c;
    int run;
    c = (idx < NC) ? bit'((cin >> idx) & 1) : 1'b0;
    run = 0;
    if (sel == 2) run = c ? len : 0;
    if (sel == 3) run = c ? 0 : len;
    if (sel == 4) run = len;
    m_done = 1'b0;
    if (sel == 1) begin
      m_remaining = 0;
    end else if (m_remaining == 0) begin
      m_remaining = run;
    end else if (ret) begin
      m_remaining = m_remaining - 1;
      m_done = (m_remaining == 0);
    end
  endtask

  task automatic cycle(input string tag, input int sel, input int idx, input int cin,
                       input int len, input bit ret);
    skip_sel     = 3'(sel);
    cond_idx     = IW'(idx);
    cond_in      = NC'(cin);
    skip_len     = CW'(len);
    instr_retire = ret;
    @(posedge cpu_clock);
    model_edge(sel, idx, cin, len, ret);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #7;
    m_remaining = 0;
    m_done = 1'b0;
    check_outputs("reset");
    @(negedge cpu_clock);
    reset_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b1;
    skip_sel = '0;
    cond_idx = '0;
    cond_in = '0;
    skip_len = '0;
    instr_retire = 1'b0;
    m_remaining = 0;
    m_done = 1'b0;
    #2;
    do_reset();

    // Reset and load via true condition, then retire the run.
    cycle("load_cond", 2, 2, 3'b100, 3, 1'b1);
    check("load_cond.count3", 32'(skip_count), 32'd3);
    cycle("run1", 0, 0, 0, 0, 1'b0);
    cycle("run2", 0, 0, 0, 0, 1'b1);
    cycle("run3", 0, 0, 0, 0, 1'b1);
    cycle("run4", 0, 0, 0, 0, 1'b1);
    check("run4.done", 32'(skip_done), 32'd1);
    cycle("run5", 0, 0, 0, 0, 1'b1);
    check("run5.done_once", 32'(skip_done), 32'd0);

    // Inverted condition: true -> no load, false -> load 5.
    cycle("inv_true",  3, 1, 3'b010, 5, 1'b1);
    check("inv_true.count", 32'(skip_count), 32'd0);
    cycle("inv_false", 3, 1, 3'b000, 5, 1'b1);
    check("inv_false.count", 32'(skip_count), 32'd5);
    cycle("clr_a", 1, 0, 0, 0, 1'b0);

    // Load ignored while skipping.
    cycle("ld2",      4, 0, 0, 2, 1'b0);
    cycle("ignore7",  4, 0, 0, 7, 1'b1);
    check("ignore7.count", 32'(skip_count), 32'd1);
    cycle("ignore_end", 0, 0, 0, 0, 1'b1);

    // CLEAR mid-run then reload.
    cycle("ld6",   4, 0, 0, 6, 1'b0);
    cycle("clear", 1, 0, 0, 0, 1'b1);
    cycle("clear_after", 0, 0, 0, 0, 1'b1);
    cycle("reload", 2, 0, 3'b001, 2, 1'b0);

    // Boundaries.
    cycle("clr_b",   1, 0, 0, 0, 1'b0);
    cycle("oor_idx", 2, 3, 3'b111, 4, 1'b0);
    check("oor_idx.count", 32'(skip_count), 32'd0);
    cycle("len0",    4, 0, 0, 0, 1'b1);
    cycle("len7",    4, 0, 0, 7, 1'b1);
    cycle("rsv6",    6, 0, 0, 3, 1'b0);
    cycle("rsv5",    5, 0, 0, 3, 1'b0);
    for (int i = 0; i < 8; i++) cycle("drain7", 0, 0, 0, 0, 1'b1);
    cycle("rsv7_idle", 7, 0, 3'b111, 5, 1'b1);

    // Async reset between edges mid-skip.
    cycle("ld4", 4, 0, 0, 4, 1'b0);
    @(negedge cpu_clock);
    #1;
    reset_n = 1'b0;
    #1;
    m_remaining = 0;
    m_done = 1'b0;
    check_outputs("async_rst");
    @(negedge cpu_clock);
    reset_n = 1'b1;
    cycle("post_rst", 0, 0, 0, 0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      int r;
      r = int'($urandom_range(0, 9));
      sel = (r < 2) ? 0 : (r < 3) ? 1 : (r < 5) ? 2 : (r < 7) ? 3 : (r < 8) ? 4 : int'($urandom_range(5, 7));
      cycle("rand", sel, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
